// File: rtl/aes_round_iter.sv
// Iterative AES encryption engine: one reused round datapath with registered
// table lookups, valid/ready handshakes and an externally indexed key schedule.
module aes_round_iter #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_state,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_state,
    output logic                busy
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_round_iter: NR must be 10, 12 or 14");
    end
    if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
        $error("aes_round_iter: RK_IDX_W too narrow to index round NR");
    end

    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        MIX  = 2'd2
    } fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[2047 - 8 * int'(a) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // T-table word for a substituted byte sitting in row r of its column.
    function automatic logic [31:0] t_word(input logic [7:0] s, input logic [1:0] r);
        logic [7:0] x2;
        logic [7:0] x3;
        x2 = xtime(s);
        x3 = x2 ^ s;
        case (r)
            2'd0:    return {x2, s,  s,  x3};
            2'd1:    return {x3, x2, s,  s };
            2'd2:    return {s,  x3, x2, s };
            default: return {s,  s,  x3, x2};
        endcase
    endfunction

    fsm_e                fsm_q, fsm_d;
    logic [127:0]        state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [127:0]        out_state_q, out_state_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          sb_q [16];
    logic [127:0]        mix_state;
    logic [127:0]        fin_state;

    // Byte i of state_q (i = 4*column + row) is looked up while in LOOK and held
    // afterwards, so a stalled final round keeps presenting the same values.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the lookup bank is ordinary flops, so it is reset like any other
        // register and never shows X downstream after reset.
        if (rst) begin
            for (int i = 0; i < 16; i++) sb_q[i] <= '0;
        end else if (fsm_q == LOOK) begin
            for (int i = 0; i < 16; i++) sb_q[i] <= sbox(state_q[127 - 8*i -: 8]);
        end
    end

    // Output column c takes row r from input column (c + r) mod 4 (ShiftRows).
    always_comb begin
        mix_state = '0;
        fin_state = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mix_state[127 - 32*c -: 32] = mix_state[127 - 32*c -: 32]
                                            ^ t_word(sb_q[((c + r) % 4) * 4 + r], 2'(r));
                fin_state[127 - 32*c - 8*r -: 8] = sb_q[((c + r) % 4) * 4 + r];
            end
        end
        mix_state = mix_state ^ rk;
        fin_state = fin_state ^ rk;
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value before the
        // case, so no branch can leave a signal unassigned and infer a latch.
        fsm_d       = fsm_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_state ^ rk;
                    rnd_d   = RK_IDX_W'(1);
                    fsm_d   = LOOK;
                end
            end
            LOOK: fsm_d = MIX;
            MIX: begin
                if (rnd_q != NR_IDX) begin
                    state_d = mix_state;
                    rnd_d   = rnd_q + RK_IDX_W'(1);
                    fsm_d   = LOOK;
                end else if (!out_valid_q || out_ready) begin
                    out_state_d = fin_state;
                    out_valid_d = 1'b1;
                    rnd_d       = '0;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                rnd_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make every register sample the values
        // present before the edge, independent of statement order.
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign rk_idx    = (fsm_q == IDLE) ? '0 : rnd_q;
    assign out_state = out_state_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_round_iter.sv
// Directed bench for aes_round_iter: three instances (NR = 10/12/14) fed by a
// bench-side key schedule whose S-box is derived from its GF(2^8) definition.
module tb_aes_round_iter;

    localparam logic [127:0] PT_A    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [191:0] KEY_192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   busy;
    logic [127:0] in_state  [3];
    logic [127:0] rk        [3];
    logic [127:0] out_state [3];
    logic [3:0]   rk_idx    [3];
    logic [127:0] rk_tab    [3][16];
    logic [7:0]   sb_tab    [256];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_iter #(.NR(10 + 2*g), .RK_IDX_W(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .rk_idx    (rk_idx[g]),
            .rk        (rk[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
        assign rk[g] = rk_tab[g][rk_idx[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // S-box from its definition: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    // Key is MSB-aligned in 256 bits; nk = 4, 6 or 8 words.
    task automatic expand(input int g, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_tab[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tab[g][r] = '0;
        end
    endtask

    // Accept one block on instance g and wait for its result with out_ready as set.
    task automatic run_block(input int g, input logic [127:0] pt, input logic [127:0] exp_ct,
                             input bit chk_rk, input bit garbage, input string tag);
        int n;
        int lat;
        lat = 2 * (10 + 2*g);
        @(negedge clk);
        check({tag, " in_ready"}, 128'(in_ready[g]), 128'(1'b1));
        if (chk_rk) check({tag, " rk_idx idle"}, 128'(rk_idx[g]), 128'(0));
        in_valid[g] = 1'b1;
        in_state[g] = pt;
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        in_state[g] = '0;
        n = 0;
        if (chk_rk) check({tag, " rk_idx e0"}, 128'(rk_idx[g]), 128'(1));
        while (!out_valid[g] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!out_valid[g]) begin
                if (chk_rk) check({tag, " rk_idx seq"}, 128'(rk_idx[g]), 128'(n/2 + 1));
                if (garbage) begin
                    in_valid[g] = 1'($urandom_range(0, 1));
                    in_state[g] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        in_valid[g] = 1'b0;
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " ciphertext"}, out_state[g], exp_ct);
        check({tag, " in_ready after"}, 128'(in_ready[g]), 128'(1'b1));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 3'b111;
        for (int g = 0; g < 3; g++) in_state[g] = '0;
        build_sbox();
        expand(0, {KEY_A, 128'h0}, 4);
        expand(1, {KEY_192, 64'h0}, 6);
        expand(2, KEY_256, 8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst out_valid", 128'(out_valid[0]), 128'(1'b0));
        check("rst in_ready", 128'(in_ready[0]), 128'(1'b1));
        check("rst busy", 128'(busy[0]), 128'(1'b0));
        check("rst rk_idx", 128'(rk_idx[0]), 128'(0));
        check("rst out_state", out_state[0], 128'h0);

        // AES-128 known answer and FIPS-197 Appendix B with round-key index trace
        run_block(0, PT_A, CT_A, 1'b0, 1'b0, "aes128_a");
        expand(0, {KEY_B, 128'h0}, 4);
        run_block(0, PT_B, CT_B, 1'b1, 1'b0, "aes128_fips");
        @(posedge clk);
        #1;
        check("pop clears out_valid", 128'(out_valid[0]), 128'(1'b0));

        // Back-to-back with the sink blocked
        out_ready[0] = 1'b0;
        expand(0, {KEY_A, 128'h0}, 4);
        run_block(0, PT_A, CT_A, 1'b0, 1'b0, "b2b first");
        expand(0, {KEY_B, 128'h0}, 4);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_state[0] = PT_B;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        check("b2b stall busy", 128'(busy[0]), 128'(1'b1));
        check("b2b stall rk_idx", 128'(rk_idx[0]), 128'(10));
        check("b2b stall out_valid", 128'(out_valid[0]), 128'(1'b1));
        check("b2b first held", out_state[0], CT_A);
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("b2b pop+load out_valid", 128'(out_valid[0]), 128'(1'b1));
        check("b2b second", out_state[0], CT_B);
        check("b2b in_ready", 128'(in_ready[0]), 128'(1'b1));
        @(posedge clk);
        #1;
        check("b2b second held", 128'(out_valid[0]), 128'(1'b1));

        // Asynchronous reset in round 5 while a result is still held
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_state[0] = PT_B;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("pre-rst busy", 128'(busy[0]), 128'(1'b1));
        rst = 1'b1;
        #1;
        check("async rst out_valid", 128'(out_valid[0]), 128'(1'b0));
        check("async rst in_ready", 128'(in_ready[0]), 128'(1'b1));
        check("async rst out_state", out_state[0], 128'h0);
        check("async rst rk_idx", 128'(rk_idx[0]), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        run_block(0, PT_B, CT_B, 1'b0, 1'b0, "after rst");

        // Garbage on the input while busy must be ignored
        run_block(0, PT_B, CT_B, 1'b0, 1'b1, "garbage");
        @(posedge clk);
        #1;
        check("garbage not accepted", 128'(busy[0]), 128'(1'b0));

        // AES-192 and AES-256
        run_block(1, PT_A, CT_192, 1'b0, 1'b0, "aes192");
        run_block(2, PT_A, CT_256, 1'b0, 1'b0, "aes256");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_iter.md
Name: aes_round_iter

Overview:
Iterative AES encryption round engine that replaces the unrolled one-round/final-round stages with a single reused round datapath. It is parametrised over round count (AES-128/192/256) and has valid/ready handshakes on input and output. It sits between the input whitening source and the ciphertext sink. An external key schedule supplies round keys by index. Each round reuses 4x table_lookup (middle rounds) and 4x S4 (final round); both are one-cycle registered lookups already in the codebase.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14; any other value is an elaboration error.
RK_IDX_W, 4, width of the round-key index; must satisfy 2**RK_IDX_W > NR.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; one clock, asynchronous, active-high.
in_valid  input  1  in_state is valid.
in_ready  output  1  engine can accept a block.
in_state  input  128  plaintext block, column-major {s0,s1,s2,s3}.
rk_idx  output  RK_IDX_W  index of the round key needed at the next state load.
rk  input  128  round key for rk_idx; must be combinationally valid in the same cycle.
out_valid  output  1  out_state holds a finished ciphertext.
out_ready  input  1  sink accepts out_state.
out_state  output  128  ciphertext register.
busy  output  1  high while a block is in flight (states LOOK/MIX).

Behaviour:
- States: IDLE, LOOK, MIX. Internal regs: state_reg[127:0], rnd[RK_IDX_W-1:0].
- Reset (async, any time, including mid-block): FSM=IDLE, rnd=0, state_reg=0, out_state=0, out_valid=0. The in-flight block is discarded silently. Combinational outputs after reset: in_ready=1, busy=0, rk_idx=0.
- in_ready = (FSM==IDLE). It does not depend on out_valid, so a new block may start while the previous result awaits out_ready.
- rk_idx = 0 in IDLE, rnd in LOOK/MIX.
- IDLE, on in_valid&&in_ready at the edge: state_reg <= in_state ^ rk (key 0 whitening), rnd <= 1, go to LOOK.
- LOOK (1 cycle): tables register lookups of state_reg, then go to MIX.
- MIX, rnd<NR: state_reg <= ShiftRows/MixColumns combine of the table outputs ^ rk. Combine per word: z0=p00^p11^p22^p33, z1=p03^p10^p21^p32, z2=p02^p13^p20^p31, z3=p01^p12^p23^p30. Then rnd <= rnd+1, go to LOOK.
- MIX, rnd==NR: final value = S4 bytes {p00,p11,p22,p33},{p10,p21,p32,p03},{p20,p31,p02,p13},{p30,p01,p12,p23} ^ rk.
  - If !out_valid || out_ready: out_state <= final value, out_valid <= 1, go to IDLE, rnd <= 0.
  - Else stall in MIX; state_reg stays unchanged, so lookups stay stable and rk_idx stays NR.
- out_valid clears on out_valid&&out_ready unless a new result loads on the same edge. Simultaneous pop and load: out_valid stays 1 and out_state takes the new value.
- Latency: accept edge E0 -> out_valid high after edge E0+2*NR (20/24/28 cycles) with no stall.
- Throughput: one block per 2*NR+1 cycles. in_ready returns the cycle after the final load.
- in_state is sampled only at the accept edge. rk is sampled only at IDLE accept and MIX load edges.
- rnd never exceeds NR. No wrap-around is reachable.

Test Plan:
- NR=10, in_state=00112233445566778899aabbccddeeff, key schedule from 000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_state=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 20 edges after accept.
- NR=10, FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32. Check rk_idx sequence 0,1,1,2,2,...,10.
- NR=14, pt 00112233445566778899aabbccddeeff, key 000102...1f -> 8ea2b7ca516745bfeafc49904b496089 after 28 edges. Also build NR=12 with key 000102...17 -> dda97ca4864cdfe06eaf70a0ec0d7191.
- Back-to-back: two blocks with out_ready=0. First result held; second stalls in MIX with rk_idx=NR and busy=1. Raise out_ready for 1 cycle -> first popped and second loaded on the same edge, out_valid stays 1.
- Assert rst for 1 cycle at round 5 -> out_valid=0, in_ready=1, out_state=0 immediately (async). A subsequent block produces the correct ciphertext.
- in_valid toggling with garbage in_state while busy -> no acceptance, result unaffected.
